time_set_ctrl: RTL

Parametrised time/alarm calibration controller for the BCD clock datapath.
- Tracks the running hr/mn/sd counters while idle.
- In set mode, edits either the time fields or the alarm fields with increment, decrement and hold-to-repeat.
- Fully synchronous, with edge detection on every button input.
- Sits between the debounced key block and the time counter / alarm comparator; issues a one-cycle load strobe to the counter on exit.

---
 rtl/time_set_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/time_set_ctrl.sv
// Time/alarm calibration controller: tracks the running BCD clock, edits time or alarm fields
// with step/auto-repeat keys, and strobes cal_load on exit. Define TIME_SET_12H_EN for 12h hours.
module time_set_ctrl #(
  parameter logic [31:0] HOLD_CYCLES   = 32'd50_000_000,
  parameter logic [31:0] REPEAT_CYCLES = 32'd10_000_000,
  parameter logic [7:0]  ALM_HR_RST    = 8'h07,
  parameter logic [7:0]  ALM_MN_RST    = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_mod,
  input  logic       set_alarm,
  input  logic       set_location,
  input  logic       time_add,
  input  logic       time_sub,
  input  logic [7:0] hr,
  input  logic [7:0] mn,
  input  logic [7:0] sd,
  output logic [7:0] hr_cal,
  output logic [7:0] mn_cal,
  output logic [7:0] sd_cal,
  output logic [7:0] alm_hr,
  output logic [7:0] alm_mn,
  output logic [1:0] option_location,
  output logic       edit_alarm,
  output logic       cal_load,
`ifdef TIME_SET_12H_EN
  output logic       pm,
  output logic       alm_pm,
  output logic [7:0] hr_cal_24,
`endif
  output logic       dbg_state_o
);

  typedef enum logic {
    ST_TRACK = 1'b0,
    ST_EDIT  = 1'b1
  } state_e;

  localparam logic [1:0] OPT_NONE = 2'd0;
  localparam logic [1:0] OPT_SEC  = 2'd1;
  localparam logic [1:0] OPT_MIN  = 2'd2;
  localparam logic [1:0] OPT_HR   = 2'd3;

  function automatic logic [7:0] bcd_up(input logic [7:0] x);
    if (x[3:0] == 4'h9) return {x[7:4] + 4'h1, 4'h0};
    return {x[7:4], x[3:0] + 4'h1};
  endfunction

  function automatic logic [7:0] bcd_dn(input logic [7:0] x);
    if (x[3:0] == 4'h0) return {x[7:4] - 4'h1, 4'h9};
    return {x[7:4], x[3:0] - 4'h1};
  endfunction

  function automatic logic [7:0] ms_step(input logic [7:0] x, input logic up);
    if (up) return (x == 8'h59) ? 8'h00 : bcd_up(x);
    return (x == 8'h00) ? 8'h59 : bcd_dn(x);
  endfunction

  function automatic logic [7:0] hr_step(input logic [7:0] x, input logic up);
`ifdef TIME_SET_12H_EN
    if (up) return (x == 8'h12) ? 8'h01 : bcd_up(x);
    return (x == 8'h01) ? 8'h12 : bcd_dn(x);
`else
    if (up) return (x == 8'h23) ? 8'h00 : bcd_up(x);
    return (x == 8'h00) ? 8'h23 : bcd_dn(x);
`endif
  endfunction

  function automatic logic [1:0] next_field(input logic [1:0] opt, input logic alarm);
    if (alarm) return (opt == OPT_MIN) ? OPT_HR : OPT_MIN;
    return (opt == OPT_HR) ? OPT_SEC : opt + 2'd1;
  endfunction

`ifdef TIME_SET_12H_EN
  // AM/PM flips when crossing the 11 <-> 12 boundary in either direction.
  function automatic logic hr_pm_flip(input logic [7:0] x, input logic up);
    return up ? (x == 8'h11) : (x == 8'h12);
  endfunction

  function automatic logic [4:0] bcd2bin(input logic [7:0] x);
    return 5'(x[7:4]) * 5'd10 + 5'(x[3:0]);
  endfunction

  function automatic logic [7:0] bin2bcd(input logic [4:0] b);
    if (b >= 5'd20) return {4'd2, 4'(b - 5'd20)};
    if (b >= 5'd10) return {4'd1, 4'(b - 5'd10)};
    return {4'd0, 4'(b)};
  endfunction

  function automatic logic [8:0] to_12h(input logic [7:0] x);
    logic [4:0] h;
    h = bcd2bin(x);
    if (h == 5'd0)  return {1'b0, 8'h12};
    if (h < 5'd12)  return {1'b0, bin2bcd(h)};
    if (h == 5'd12) return {1'b1, 8'h12};
    return {1'b1, bin2bcd(h - 5'd12)};
  endfunction

  function automatic logic [7:0] to_24h(input logic [7:0] x, input logic is_pm);
    logic [4:0] h;
    h = bcd2bin(x);
    if (is_pm) return (h == 5'd12) ? 8'h12 : bin2bcd(h + 5'd12);
    return (h == 5'd12) ? 8'h00 : bin2bcd(h);
  endfunction
`endif

  state_e      state_q, state_d;
  logic [7:0]  hr_cal_q, hr_cal_d, mn_cal_q, mn_cal_d, sd_cal_q, sd_cal_d;
  logic [7:0]  alm_hr_q, alm_hr_d, alm_mn_q, alm_mn_d;
  logic [1:0]  opt_q, opt_d;
  logic        ea_q, ea_d;
  logic        dirty_q, dirty_d;
  logic        load_q, load_d;
  logic        mod_q, loc_q, add_q, sub_q;
  logic [31:0] cnt_q, cnt_d;
  logic        rep_q, rep_d;
`ifdef TIME_SET_12H_EN
  logic        pm_q, pm_d, alm_pm_q, alm_pm_d;
`endif

  logic        mod_rise, mod_fall, loc_rise, add_rise, sub_rise;
  logic        key_act, step, step_up;
  logic [31:0] target;

  assign mod_rise = set_mod & ~mod_q;
  assign mod_fall = ~set_mod & mod_q;
  assign loc_rise = set_location & ~loc_q;
  assign add_rise = time_add & ~add_q;
  assign sub_rise = time_sub & ~sub_q;

  // Exactly one of add/sub held counts as an active key; both together is a no-op.
  assign key_act = time_add ^ time_sub;
  assign step_up = time_add;
  assign target  = rep_q ? REPEAT_CYCLES : HOLD_CYCLES;

  // cnt_q counts cycles since the last step; zero means no repeat sequence is running.
  always_comb begin
    step  = 1'b0;
    cnt_d = cnt_q;
    rep_d = rep_q;
    if (!key_act) begin
      cnt_d = 32'd0;
      rep_d = 1'b0;
    end else if (add_rise | sub_rise) begin
      step  = 1'b1;
      cnt_d = 32'd1;
      rep_d = 1'b0;
    end else if (cnt_q != 32'd0) begin
      if (cnt_q == target) begin
        step  = 1'b1;
        cnt_d = 32'd1;
        rep_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_TRACK;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_TRACK: if (mod_rise) state_d = ST_EDIT;
      ST_EDIT:  if (mod_fall) state_d = ST_TRACK;
      default:  state_d = ST_TRACK;
    endcase
  end

  // cal_load is a bare one-cycle strobe with no back-pressure: the counter must take it when seen.
  always_comb begin
    hr_cal_d = hr_cal_q;
    mn_cal_d = mn_cal_q;
    sd_cal_d = sd_cal_q;
    alm_hr_d = alm_hr_q;
    alm_mn_d = alm_mn_q;
    opt_d    = opt_q;
    ea_d     = ea_q;
    dirty_d  = dirty_q;
    load_d   = 1'b0;
`ifdef TIME_SET_12H_EN
    pm_d     = pm_q;
    alm_pm_d = alm_pm_q;
`endif
    case (state_q)
      ST_TRACK: begin
`ifdef TIME_SET_12H_EN
        {pm_d, hr_cal_d} = to_12h(hr);
`else
        hr_cal_d = hr;
`endif
        mn_cal_d = mn;
        sd_cal_d = sd;
        if (mod_rise) begin
          ea_d    = set_alarm;
          opt_d   = set_alarm ? OPT_MIN : OPT_SEC;
          dirty_d = 1'b0;
        end
      end
      ST_EDIT: begin
        // The step uses the registered field, so a simultaneous location change lands next cycle.
        if (step) begin
          case (opt_q)
            OPT_SEC: begin
              if (!ea_q) begin
                sd_cal_d = ms_step(sd_cal_q, step_up);
                dirty_d  = 1'b1;
              end
            end
            OPT_MIN: begin
              if (ea_q) begin
                alm_mn_d = ms_step(alm_mn_q, step_up);
              end else begin
                mn_cal_d = ms_step(mn_cal_q, step_up);
                dirty_d  = 1'b1;
              end
            end
            OPT_HR: begin
              if (ea_q) begin
                alm_hr_d = hr_step(alm_hr_q, step_up);
`ifdef TIME_SET_12H_EN
                alm_pm_d = alm_pm_q ^ hr_pm_flip(alm_hr_q, step_up);
`endif
              end else begin
                hr_cal_d = hr_step(hr_cal_q, step_up);
`ifdef TIME_SET_12H_EN
                pm_d     = pm_q ^ hr_pm_flip(hr_cal_q, step_up);
`endif
                dirty_d  = 1'b1;
              end
            end
            default: ;
          endcase
        end
        if (loc_rise) opt_d = next_field(opt_q, ea_q);
        if (mod_fall) begin
          opt_d  = OPT_NONE;
          ea_d   = 1'b0;
          load_d = dirty_d;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hr_cal_q <= 8'h00;
      mn_cal_q <= 8'h00;
      sd_cal_q <= 8'h00;
      alm_hr_q <= ALM_HR_RST;
      alm_mn_q <= ALM_MN_RST;
      opt_q    <= OPT_NONE;
      ea_q     <= 1'b0;
      dirty_q  <= 1'b0;
      load_q   <= 1'b0;
      mod_q    <= 1'b0;
      loc_q    <= 1'b0;
      add_q    <= 1'b0;
      sub_q    <= 1'b0;
      cnt_q    <= 32'd0;
      rep_q    <= 1'b0;
`ifdef TIME_SET_12H_EN
      pm_q     <= 1'b0;
      alm_pm_q <= 1'b0;
`endif
    end else begin
      hr_cal_q <= hr_cal_d;
      mn_cal_q <= mn_cal_d;
      sd_cal_q <= sd_cal_d;
      alm_hr_q <= alm_hr_d;
      alm_mn_q <= alm_mn_d;
      opt_q    <= opt_d;
      ea_q     <= ea_d;
      dirty_q  <= dirty_d;
      load_q   <= load_d;
      mod_q    <= set_mod;
      loc_q    <= set_location;
      add_q    <= time_add;
      sub_q    <= time_sub;
      cnt_q    <= cnt_d;
      rep_q    <= rep_d;
`ifdef TIME_SET_12H_EN
      pm_q     <= pm_d;
      alm_pm_q <= alm_pm_d;
`endif
    end
  end

  assign hr_cal          = hr_cal_q;
  assign mn_cal          = mn_cal_q;
  assign sd_cal          = sd_cal_q;
  assign alm_hr          = alm_hr_q;
  assign alm_mn          = alm_mn_q;
  assign option_location = opt_q;
  assign edit_alarm      = ea_q;
  assign cal_load        = load_q;
  assign dbg_state_o     = state_q;
`ifdef TIME_SET_12H_EN
  assign pm        = pm_q;
  assign alm_pm    = alm_pm_q;
  assign hr_cal_24 = to_24h(hr_cal_q, pm_q);
`endif

endmodule
